// File: rtl/sys_defs.sv
// Shared CDB definitions: functional-unit slot order, tag/value widths and the
// broadcast packet snooped by the reservation station and map table.
package sys_defs;

    localparam int NUM_FU = 5;
    localparam int TAG_W  = 6;
    localparam int XLEN   = 32;
    localparam int SRC_W  = $clog2(NUM_FU);

    // Index order matches the reservation-station slot order
    localparam int FU_ALU = 0;
    localparam int FU_LD  = 1;
    localparam int FU_ST  = 2;
    localparam int FU_FP1 = 3;
    localparam int FU_FP2 = 4;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
        logic [SRC_W-1:0] src;
    } CDB_PACKET;

endpackage

// File: rtl/cdb_fifo.sv
// Per-FU completion queue: small circular FIFO with occupancy count and a
// flush that empties it in one edge. Storage itself is never reset.
module cdb_fifo #(
    parameter int QDEPTH = 2,
    parameter int WIDTH  = 38
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH) + 1;

    logic [WIDTH-1:0] mem [QDEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A push into a full queue is refused rather than overwriting the oldest entry
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(QDEPTH));
    assign head  = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmit side: buffers FU completions per unit and broadcasts one per
// cycle through a round-robin grant into a registered packet.
module cdb_arbiter
    import sys_defs::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [NUM_FU-1:0]       fu_done,
    input  logic [NUM_FU*TAG_W-1:0] fu_tag,
    input  logic [NUM_FU*XLEN-1:0]  fu_value,
    output logic [NUM_FU-1:0]       fu_stall,
    output logic                    cdb_valid,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [XLEN-1:0]         cdb_value,
    output logic [SRC_W-1:0]        cdb_src
);

    localparam int ENT_W = TAG_W + XLEN;

    logic [NUM_FU-1:0] q_empty;
    logic [NUM_FU-1:0] q_full;
    logic [NUM_FU-1:0] q_push;
    logic [NUM_FU-1:0] q_pop;
    logic [ENT_W-1:0]  q_head [NUM_FU];

    logic [NUM_FU-1:0] accept_p0;
    logic [NUM_FU-1:0] cand_vld_p0;
    logic [ENT_W-1:0]  cand_p0 [NUM_FU];
    logic              grant_vld_p0;
    logic [SRC_W-1:0]  grant_idx_p0;
    logic [ENT_W-1:0]  grant_ent_p0;

    logic [SRC_W-1:0]  rr_ptr;
    CDB_PACKET         cdb_pkt_p1;

    function automatic logic [SRC_W-1:0] src_inc(input logic [SRC_W-1:0] s);
        return (s == SRC_W'(NUM_FU - 1)) ? '0 : s + SRC_W'(1);
    endfunction

    // ---- stage p0: per-FU candidate (queue head, else bypassed incoming report)
    genvar i;
    generate
        for (i = 0; i < NUM_FU; i++) begin : g_fu
            logic granted;

            // Tag 0 is the architectural zero register and never reaches the bus
            assign accept_p0[i]   = fu_done[i] & ~q_full[i] & ~flush
                                    & (fu_tag[i*TAG_W +: TAG_W] != '0);
            assign cand_vld_p0[i] = ~q_empty[i] | accept_p0[i];
            assign cand_p0[i]     = q_empty[i]
                                    ? {fu_tag[i*TAG_W +: TAG_W], fu_value[i*XLEN +: XLEN]}
                                    : q_head[i];

            assign granted   = grant_vld_p0 & (grant_idx_p0 == SRC_W'(i));
            assign q_pop[i]  = granted & ~q_empty[i];
            assign q_push[i] = accept_p0[i] & ~(granted & q_empty[i]);

            cdb_fifo #(
                .QDEPTH (QDEPTH),
                .WIDTH  (ENT_W)
            ) u_fifo (
                .clock   (clock),
                .reset   (reset),
                .flush   (flush),
                .push    (q_push[i]),
                .pop     (q_pop[i]),
                .data_in ({fu_tag[i*TAG_W +: TAG_W], fu_value[i*XLEN +: XLEN]}),
                .head    (q_head[i]),
                .empty   (q_empty[i]),
                .full    (q_full[i])
            );
        end
    endgenerate

    // Stall depends on occupancy alone, keeping arbitration off the FU handshake path
    assign fu_stall = q_full;

    // Descending scan so the candidate nearest rr_ptr is the one left standing
    always_comb begin
        int               sum;
        logic [SRC_W-1:0] idx;
        grant_vld_p0 = 1'b0;
        grant_idx_p0 = '0;
        sum          = 0;
        idx          = '0;
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            sum = int'(rr_ptr) + k;
            if (sum >= NUM_FU) sum = sum - NUM_FU;
            idx = SRC_W'(sum);
            if (cand_vld_p0[idx]) begin
                grant_vld_p0 = 1'b1;
                grant_idx_p0 = idx;
            end
        end
        grant_ent_p0 = cand_p0[grant_idx_p0];
    end

    // ---- stage p1: registered CDB packet and round-robin pointer
    always_ff @(posedge clock) begin
        if (reset) begin
            cdb_pkt_p1 <= '0;
            rr_ptr     <= '0;
        end else if (flush) begin
            cdb_pkt_p1.valid <= 1'b0;
            rr_ptr           <= '0;
        end else begin
            cdb_pkt_p1.valid <= grant_vld_p0;
            if (grant_vld_p0) begin
                cdb_pkt_p1.tag   <= grant_ent_p0[ENT_W-1 -: TAG_W];
                cdb_pkt_p1.value <= grant_ent_p0[XLEN-1:0];
                cdb_pkt_p1.src   <= grant_idx_p0;
                rr_ptr           <= src_inc(grant_idx_p0);
            end
        end
    end

    assign cdb_valid = cdb_pkt_p1.valid;
    assign cdb_tag   = cdb_pkt_p1.tag;
    assign cdb_value = cdb_pkt_p1.value;
    assign cdb_src   = cdb_pkt_p1.src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-based reference model predicts
// each cycle's CDB packet; a separate monitor compares what the DUT presents.
`timescale 1ns/1ps
module tb_cdb_arbiter;
    import sys_defs::*;

    localparam int QDEPTH = 2;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic                    flush = 1'b0;
    logic [NUM_FU-1:0]       fu_done = '0;
    logic [NUM_FU*TAG_W-1:0] fu_tag = '0;
    logic [NUM_FU*XLEN-1:0]  fu_value = '0;
    logic [NUM_FU-1:0]       fu_stall;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [XLEN-1:0]         cdb_value;
    logic [SRC_W-1:0]        cdb_src;

    cdb_arbiter #(.QDEPTH(QDEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .fu_done   (fu_done),
        .fu_tag    (fu_tag),
        .fu_value  (fu_value),
        .fu_stall  (fu_stall),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value),
        .cdb_src   (cdb_src)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int               due;
        logic             vld;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  val;
        logic [SRC_W-1:0] src;
    } exp_t;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  val;
    } rep_t;

    exp_t exp_q[$];
    rep_t mq[NUM_FU][$];
    int               m_rr  = 0;
    logic             m_vld = 1'b0;
    logic [TAG_W-1:0] m_tag = '0;
    logic [XLEN-1:0]  m_val = '0;
    logic [SRC_W-1:0] m_src = '0;

    logic [TAG_W-1:0] t_tag [NUM_FU];
    logic [XLEN-1:0]  t_val [NUM_FU];

    // Reference: per-FU FIFOs of reports, rotating priority starting at m_rr
    task automatic model_step(input logic [NUM_FU-1:0] d, input bit fl, input bit rs);
        bit   acc [NUM_FU];
        int   g;
        rep_t r;
        if (rs) begin
            for (int i = 0; i < NUM_FU; i++) mq[i].delete();
            m_rr = 0; m_vld = 1'b0; m_tag = '0; m_val = '0; m_src = '0;
        end else if (fl) begin
            for (int i = 0; i < NUM_FU; i++) mq[i].delete();
            m_rr = 0; m_vld = 1'b0;
        end else begin
            g = -1;
            for (int i = 0; i < NUM_FU; i++)
                acc[i] = d[i] && (mq[i].size() < QDEPTH) && (t_tag[i] != '0);
            for (int k = 0; k < NUM_FU; k++) begin
                int f;
                f = (m_rr + k) % NUM_FU;
                if (g < 0 && (mq[f].size() > 0 || acc[f])) g = f;
            end
            m_vld = (g >= 0);
            if (g >= 0) begin
                if (mq[g].size() > 0) begin
                    r = mq[g].pop_front();
                end else begin
                    r.tag  = t_tag[g];
                    r.val  = t_val[g];
                    acc[g] = 1'b0;
                end
                m_tag = r.tag;
                m_val = r.val;
                m_src = SRC_W'(g);
                m_rr  = (g + 1) % NUM_FU;
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (acc[i]) begin
                    r.tag = t_tag[i];
                    r.val = t_val[i];
                    mq[i].push_back(r);
                end
            end
        end
    endtask

    // One cycle of stimulus; want bits are held back while the model says stalled
    // unless forced, in which case the DUT must ignore them.
    task automatic step(input logic [NUM_FU-1:0] want, input logic [NUM_FU-1:0] force_m,
                        input bit fl, input bit rs);
        logic [NUM_FU-1:0] d;
        exp_t              e;
        @(posedge clock);
        #1;
        for (int i = 0; i < NUM_FU; i++) begin
            logic exp_stall;
            exp_stall = (mq[i].size() == QDEPTH);
            n_tests++;
            if (fu_stall[i] !== exp_stall) begin
                n_fail++;
                $display("FAIL fu_stall[%0d] cyc=%0d got=%0b exp=%0b", i, cyc, fu_stall[i], exp_stall);
            end
            d[i] = want[i] && (force_m[i] || !exp_stall);
            if (d[i] && exp_stall && !rs)
                $display("[TB] note: FU %0d fu_done while stalled (protocol violation, must be ignored)", i);
            fu_tag[i*TAG_W +: TAG_W] = t_tag[i];
            fu_value[i*XLEN +: XLEN] = t_val[i];
        end
        fu_done = d;
        flush   = fl;
        reset   = rs;
        model_step(d, fl, rs);
        e.due = cyc + 1;
        e.vld = m_vld;
        e.tag = m_tag;
        e.val = m_val;
        e.src = m_src;
        exp_q.push_back(e);
    endtask

    task automatic set_rep(input int i, input int tag, input logic [XLEN-1:0] val);
        t_tag[i] = TAG_W'(tag);
        t_val[i] = val;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step('0, '0, 1'b0, 1'b0);
    endtask

    // Monitor: compares the registered CDB packet against the prediction due now
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                n_tests++;
                if ({cdb_valid, cdb_tag, cdb_value, cdb_src} !== {e.vld, e.tag, e.val, e.src}) begin
                    n_fail++;
                    $display("FAIL cdb cyc=%0d got v=%0b tag=%0d val=%h src=%0d exp v=%0b tag=%0d val=%h src=%0d",
                             cyc, cdb_valid, cdb_tag, cdb_value, cdb_src, e.vld, e.tag, e.val, e.src);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NUM_FU; i++) set_rep(i, 0, '0);

        // Reset state
        step('0, '0, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1);
        idle(2);

        // Single ALU completion
        set_rep(FU_ALU, 5, 32'h1234);
        step(5'b00001, '0, 1'b0, 1'b0);
        idle(3);

        // All five at once, tags 1..5
        for (int i = 0; i < NUM_FU; i++) set_rep(i, i + 1, 32'hA000 + i);
        step(5'b11111, '0, 1'b0, 1'b0);
        idle(6);

        // ALU and FP1 every cycle: alternating grants
        for (int c = 0; c < 12; c++) begin
            set_rep(FU_ALU, 10 + c, $urandom);
            set_rep(FU_FP1, 30 + c, $urandom);
            step(5'b01001, '0, 1'b0, 1'b0);
        end
        idle(8);

        // Back-pressure on LD while everyone else competes; LD keeps asserting through stall
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < NUM_FU; i++) set_rep(i, 40 + 4 * i + (c % 4), $urandom);
            set_rep(FU_LD, 20 + c, 32'hB000 + c);
            step(5'b11111, 5'b00010, 1'b0, 1'b0);
        end
        idle(14);

        // Flush with entries queued; done in the flush cycle is dropped
        for (int i = 0; i < NUM_FU; i++) set_rep(i, 50 + i, $urandom);
        step(5'b11111, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        set_rep(FU_ALU, 60, 32'hDEAD);
        step(5'b00001, '0, 1'b1, 1'b0);
        idle(4);

        // Zero tag never broadcast
        set_rep(FU_ALU, 0, 32'h5555);
        step(5'b00001, '0, 1'b0, 1'b0);
        idle(3);

        // Reset mid-operation, then a fresh FP2 completion
        for (int i = 0; i < NUM_FU; i++) set_rep(i, 11 + i, $urandom);
        step(5'b11111, '0, 1'b0, 1'b0);
        step(5'b11111, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b1);
        idle(1);
        set_rep(FU_FP2, 9, 32'h0909);
        step(5'b10000, '0, 1'b0, 1'b0);
        idle(3);

        // Randomized traffic with occasional zero tags, flushes and resets
        for (int c = 0; c < 1500; c++) begin
            logic [NUM_FU-1:0] w;
            bit fl;
            bit rs;
            for (int i = 0; i < NUM_FU; i++)
                set_rep(i, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63), $urandom);
            w  = NUM_FU'($urandom) & NUM_FU'($urandom | $urandom);
            fl = ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 299) == 0);
            step(w, '0, fl, rs);
        end
        idle(5);

        @(negedge clock);
        @(negedge clock);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
